// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Instruction format enum, opcode/funct constants and packing
//            helpers shared between the encoder and the core.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_J   = 2'b10,
        FMT_RSV = 2'b11
    } fmt_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;

    // True when a 32-bit immediate is representable as a sign-extended 16-bit field.
    function automatic logic imm_fits16(input logic [31:0] imm);
        return imm[31:16] == {16{imm[15]}};
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO, power-of-two depth, synchronous reset,
//            show-ahead read data.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    // Status flags and pointer advance; writes and reads are gated by full/empty.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + (do_wr ? 1'b1 : 1'b0);
        rd_ptr_d = rd_ptr_q + (do_rd ? 1'b1 : 1'b0);
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Packs R/I/J instruction fields into 32-bit words, tags each with
//            a running byte address and buffers them in an output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [31:0] immediate,
    input  logic [25:0] jumpaddr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [15:0] count
);

    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic [15:0] count_q, count_d;

    logic        fifo_full, fifo_empty;
    logic [63:0] fifo_rd_data;
    logic [31:0] word;
    logic        req_ok, accept, push, pop;

    // Field packing and request legality.
    always_comb begin
        word   = '0;
        req_ok = 1'b0;
        case (fmt_t'(fmt))
            FMT_R: begin
                word   = {opcode, rs, rt, rd, shamt, funct};
                req_ok = 1'b1;
            end
            FMT_I: begin
                word   = {opcode, rs, rt, immediate[15:0]};
                req_ok = imm_fits16(immediate);
            end
            FMT_J: begin
                word   = {opcode, jumpaddr};
                req_ok = 1'b1;
            end
            default: begin
                word   = '0;
                req_ok = 1'b0;
            end
        endcase
    end

    // Handshakes: ready depends only on occupancy, never on a same-cycle pop.
    always_comb begin
        in_ready  = !fifo_full && !clear && !rst;
        accept    = in_valid && in_ready;
        push      = accept && req_ok;
        out_valid = !fifo_empty;
        pop       = out_valid && out_ready;
        out_word  = fifo_rd_data[63:32];
        out_addr  = fifo_rd_data[31:0];
        err       = err_q;
        count     = count_q;
    end

    // Next-state for address, sticky error and saturating transfer count.
    always_comb begin
        addr_d  = addr_q;
        err_d   = err_q;
        count_d = count_q;
        if (clear) begin
            addr_d  = BASE_ADDR;
            err_d   = 1'b0;
            count_d = '0;
        end else begin
            if (push) begin
                addr_d = addr_q + 32'd4;
            end
            if (accept && !req_ok) begin
                err_d = 1'b1;
            end
            if (pop && (count_q != 16'hFFFF)) begin
                count_d = count_q + 16'd1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= BASE_ADDR;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // Clear flushes the buffer exactly like reset does.
    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst || clear),
        .wr_en   (push),
        .wr_data ({word, addr_q}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule : instr_encoder
`default_nettype wire
